// File: rtl/friscv_pkg.sv
// Shared definitions for the FRISCV RAM controller slice.
//
// Contents:
//   ram_ctrl_state_t : FSM states of friscv_ram_ctrl (IDLE, RMW_RD, RMW_WR)
//   RAM_LAT_MIN/MAX  : range of supported RAM read latencies
//   ram_lat_legal    : helper that checks a latency against that range
package friscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } ram_ctrl_state_t;

    localparam int RAM_LAT_MIN = 0;
    localparam int RAM_LAT_MAX = 1;

    function automatic logic ram_lat_legal(input int lat);
        return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
    endfunction

endpackage

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO used as the response buffer of friscv_ram_ctrl.
//
// Ports:
//   aclk, srst          : clock and synchronous active-high reset (empties FIFO)
//   push, push_data     : write one entry
//   push2, push2_data   : write a second, younger entry in the same cycle
//                         (only legal together with push)
//   pop                 : drop the head entry
//   pop_data            : head entry, valid while empty is low
//   empty, count        : occupancy status
//
// Push and pop in the same cycle are legal, also when the FIFO is full.
// The caller guarantees it never pushes more than the free space.
module friscv_scfifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic                       aclk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       push2,
    input  logic [WIDTH-1:0]           push2_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // The second push lands in the slot right after the first one, so the
    // older entry is always read out first.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (push2) begin
            mem_d[next_ptr(wr_ptr_q)] = push2_data;
            wr_ptr_d                  = next_ptr(next_ptr(wr_ptr_q));
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) + CNT_W'(push2) - CNT_W'(pop);
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/friscv_ram_ctrl.sv
// Request/response front end for a single-port RAM with byte strobes.
//
// Ports:
//   aclk, srst                        : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake
//   req_wr, req_addr, req_data,
//   req_strb                          : request payload (strobes used by writes)
//   rsp_valid/rsp_ready               : response handshake
//   rsp_wr, rsp_data                  : 1 = write ack (data 0), 0 = read data
//   ram_wren, ram_addr, ram_wdata     : RAM command, all zero when idle
//   ram_rdata                         : RAM read data, RAM_LAT cycles after address
//
// Reads and full-strobe writes complete in the handshake cycle; empty-strobe
// writes only ack; partial-strobe writes run a read-modify-write sequence.
// Responses come back in acceptance order through a 2-entry FIFO.
module friscv_ram_ctrl
    import friscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_LAT    = 1
) (
    input  logic                    aclk,
    input  logic                    srst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_wr,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    ram_wren,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int RSP_W      = DATA_WIDTH + 1;
    localparam int FIFO_DEPTH = 2;

    if (!ram_lat_legal(RAM_LAT)) begin : g_bad_ram_lat
        $error("friscv_ram_ctrl: RAM_LAT must be 0 or 1");
    end

    ram_ctrl_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [STRB_W-1:0]      strb_q, strb_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   rd_pend_q, rd_pend_d;

    logic                   accept;
    logic                   rd_push;
    logic                   ack_push;
    logic [2:0]             occupancy;

    logic                   fifo_push;
    logic [RSP_W-1:0]       fifo_push_data;
    logic                   fifo_push2;
    logic [RSP_W-1:0]       fifo_pop_data;
    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [1:0]             fifo_count;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_d,
        input logic [DATA_WIDTH-1:0] old_d,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_d;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                r[i*8 +: 8] = new_d[i*8 +: 8];
            end
        end
        return r;
    endfunction

    // Pending read data already owns a FIFO slot, so it counts toward the
    // occupancy that throttles new requests.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pend_q};
    assign req_ready = !srst && (state_q == IDLE) && (occupancy < 3'd2);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        rd_pend_d = 1'b0;
        ram_wren  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rd_push   = rd_pend_q;
        ack_push  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_wr) begin
                        ram_addr = req_addr;
                        if (RAM_LAT == 0) begin
                            rd_push = 1'b1;
                        end else begin
                            rd_pend_d = 1'b1;
                        end
                    end else if (&req_strb) begin
                        ram_wren  = 1'b1;
                        ram_addr  = req_addr;
                        ram_wdata = req_data;
                        ack_push  = 1'b1;
                    end else if (~|req_strb) begin
                        ack_push = 1'b1;
                    end else begin
                        // Partial write: fetch the old word first.
                        ram_addr = req_addr;
                        addr_d   = req_addr;
                        data_d   = req_data;
                        strb_d   = req_strb;
                        if (RAM_LAT == 0) begin
                            wdata_d = merge_bytes(req_data, ram_rdata, req_strb);
                            state_d = RMW_WR;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            RMW_RD: begin
                wdata_d = merge_bytes(data_q, ram_rdata, strb_q);
                state_d = RMW_WR;
            end
            RMW_WR: begin
                ram_wren  = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                ack_push  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing reaches the RAM while reset is held, even mid-RMW.
        if (srst) begin
            ram_wren  = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // With RAM_LAT = 1 an older read's data and a new write ack can land in
    // the same cycle; the read data goes first to keep acceptance order.
    assign fifo_push      = rd_push || ack_push;
    assign fifo_push_data = rd_push ? {1'b0, ram_rdata} : {1'b1, {DATA_WIDTH{1'b0}}};
    assign fifo_push2     = rd_push && ack_push;
    assign fifo_pop       = rsp_valid && rsp_ready;

    friscv_scfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .aclk       (aclk),
        .srst       (srst),
        .push       (fifo_push),
        .push_data  (fifo_push_data),
        .push2      (fifo_push2),
        .push2_data ({1'b1, {DATA_WIDTH{1'b0}}}),
        .pop        (fifo_pop),
        .pop_data   (fifo_pop_data),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign rsp_valid = !srst && !fifo_empty;
    assign rsp_wr    = rsp_valid ? fifo_pop_data[DATA_WIDTH] : 1'b0;
    assign rsp_data  = rsp_valid ? fifo_pop_data[DATA_WIDTH-1:0] : '0;

endmodule

// File: doc/friscv_ram_ctrl.md
FRISCV_RAM_CTRL -- requirements
Module: friscv_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: RAM word width, multiple of 8.
REQ-003 SHALL have parameter RAM_LAT, default 1: RAM read latency in cycles, 0 or 1; other values are illegal.
REQ-004 SHALL have ports:
  aclk  in  1  clock, all logic on rising edge
  srst  in  1  reset, synchronous, active-high
  req_valid  in  1  request valid
  req_ready  out  1  request accepted when valid and ready
  req_wr  in  1  1 = write, 0 = read
  req_addr  in  ADDR_WIDTH  word address
  req_data  in  DATA_WIDTH  write data
  req_strb  in  DATA_WIDTH/8  byte enables, writes only
  rsp_valid  out  1  response valid
  rsp_ready  in  1  response consumed when valid and ready
  rsp_wr  out  1  response type: 1 = write ack, 0 = read data
  rsp_data  out  DATA_WIDTH  read data; 0 on write acks
  ram_wren  out  1  RAM write enable
  ram_addr  out  ADDR_WIDTH  RAM address
  ram_wdata  out  DATA_WIDTH  RAM write data
  ram_rdata  in  DATA_WIDTH  RAM read data, valid RAM_LAT cycles after the address

Function
REQ-005 SHALL return exactly one response per accepted request, in acceptance order.
REQ-006 SHALL use a 3-state FSM: IDLE, RMW_RD, RMW_WR.
REQ-007 SHALL assert req_ready only in IDLE, and only when response-buffer occupancy plus in-flight reads is below 2.
REQ-008 SHALL handle a read in IDLE in the handshake cycle: ram_addr = req_addr, ram_wren = 0; push ram_rdata into the response buffer RAM_LAT cycles later with rsp_wr = 0.
REQ-009 SHALL handle a write with req_strb all ones in IDLE in the handshake cycle: ram_wren = 1, ram_wdata = req_data; push an ack in the same cycle; stay in IDLE.
REQ-010 SHALL handle a write with req_strb all zeros by not writing the RAM; ack only, pushed in the handshake cycle.
REQ-011 SHALL handle a partial-strobe write as read-modify-write:
  - Handshake cycle: issue the read and go to RMW_RD; register address, data and strobe.
  - RMW_RD: wait RAM_LAT cycles (RAM_LAT = 0: merge in the handshake cycle, go directly to RMW_WR).
  - Merge: enabled bytes from req_data, the rest from ram_rdata.
  - RMW_WR: one cycle with ram_wren = 1; push the ack; return to IDLE.
REQ-012 SHALL hold req_ready low throughout RMW_RD and RMW_WR.
REQ-013 SHALL implement a 2-entry response FIFO:
  - rsp_valid is high whenever the FIFO is non-empty.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
  - Overflow is impossible by REQ-007.
REQ-014 SHALL keep rsp_data and rsp_wr stable while rsp_valid is high and rsp_ready is low.
REQ-015 SHALL return new data for a read accepted the cycle after a write to the same address (no bypass path needed).
REQ-016 SHALL sustain throughput of one read or full-strobe write per cycle while rsp_ready stays high.
REQ-017 SHALL drive ram_wren = 0 and ram_addr = 0 in every cycle with no RAM access.

Reset
REQ-018 SHALL, while srst is high:
  - set the FSM to IDLE;
  - empty the FIFO;
  - clear in-flight read tracking;
  - drive req_ready, rsp_valid, rsp_wr, rsp_data, ram_wren, ram_addr and ram_wdata to 0.
REQ-019 SHALL discard, with no response, any request in flight when srst asserts (including mid-RMW); no RAM write after srst.
REQ-020 SHALL assert req_ready in the first cycle after srst deasserts.

Structure
REQ-021 SHALL define the FSM state enum and the RAM_LAT legal-value constants in the shared package friscv_pkg.
REQ-022 SHALL instantiate friscv_scfifo (depth 2, width DATA_WIDTH+1) as its only sub-module, for the response buffer.

Verification (bench drives a friscv_dpram with FFD_EN = RAM_LAT; DATA_WIDTH = 32)
REQ-023 SHALL cover: write 0xDEADBEEF, strb 0xF, to addr 0x10, then read 0x10 -> ack (rsp_wr = 1, rsp_data = 0) then rsp_data 0xDEADBEEF; one request per cycle.
REQ-024 SHALL cover: mem[0x04] = 0x11223344; write 0xAABBCCDD, strb 0x5 -> req_ready low 1+RAM_LAT cycles, ack; read 0x04 returns 0x11BB33DD.
REQ-025 SHALL cover: rsp_ready low, 4 back-to-back reads -> 2 accepted, req_ready low, rsp_data stable; release -> all 4 returned in order.
REQ-026 SHALL cover: write strb 0x0 to addr 0x20 holding 0x55 -> ack, no ram_wren pulse, read returns 0x55.
REQ-027 SHALL cover: srst asserted in RMW_RD -> no ram_wren and rsp_valid 0 the next cycle; target word unchanged; req_ready high the first cycle after srst falls.
REQ-028 SHALL run REQ-023..027 with RAM_LAT = 0 and RAM_LAT = 1.
